mem_stage_lsu: RTL and testbench

- MEM-stage load/store unit for the pipelined MIPS core; successor of the single-cycle data-memory stage.
- Adds parametrised data and address widths and byte-lane write enables.
- Adds alignment checking and a configurable-latency memory access, with a stall handshake back to the pipeline.
- Registers the MEM/WB pipeline outputs and exposes a debug read port.

---
 rtl/mem_lsu_pkg.sv | 61 ++++++
 rtl/mem_stage_lsu_ram.sv | 43 ++++
 rtl/mem_stage_lsu.sv | 167 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared encodings and helper functions for the MEM-stage load/store unit.
// Helpers work on the widest (64-bit, 8-lane) datapath; callers size-cast the results.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    W_BYTE  = 2'b00,
    W_HALF  = 2'b01,
    W_WORD  = 2'b10,
    W_DWORD = 2'b11
  } width_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam int MAX_LANES = 8;
  localparam int MAX_DATA  = 64;

  function automatic logic is_aligned(input width_e width, input logic [2:0] off,
                                      input logic dword_ok);
    logic ok;
    case (width)
      W_BYTE:  ok = 1'b1;
      W_HALF:  ok = (off[0] == 1'b0);
      W_WORD:  ok = (off[1:0] == 2'b00);
      default: ok = dword_ok && (off == 3'b000);
    endcase
    return ok;
  endfunction

  function automatic logic [MAX_LANES-1:0] gen_byte_en(input width_e width,
                                                       input logic [2:0] off);
    logic [MAX_LANES-1:0] mask;
    case (width)
      W_BYTE:  mask = 8'h01;
      W_HALF:  mask = 8'h03;
      W_WORD:  mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << off;
  endfunction

  // Word loads are extended from bit 31 even on a 64-bit datapath.
  function automatic logic [MAX_DATA-1:0] load_extract(input logic [MAX_DATA-1:0] word,
                                                       input logic [2:0] off,
                                                       input width_e width,
                                                       input logic sign);
    logic [MAX_DATA-1:0] sh;
    logic [MAX_DATA-1:0] res;
    sh = word >> {off, 3'b000};
    case (width)
      W_BYTE:  res = {{56{sign & sh[7]}}, sh[7:0]};
      W_HALF:  res = {{48{sign & sh[15]}}, sh[15:0]};
      W_WORD:  res = {{32{sign & sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_ram.sv
// Byte-banked data memory: per-lane synchronous write, registered access and debug reads.
// A write and a read of the same word in one cycle returns the old contents.
module byte_lane_ram #(
  parameter int LANES    = 4,
  parameter int NB_WADDR = 8
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [NB_WADDR-1:0]   i_addr,
  input  logic [LANES-1:0]      i_we,
  input  logic [8*LANES-1:0]    i_wdata,
  output logic [8*LANES-1:0]    o_rdata,
  input  logic [NB_WADDR-1:0]   i_dbg_addr,
  output logic [8*LANES-1:0]    o_dbg_data
);

  localparam int DEPTH = 1 << NB_WADDR;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] bank_q [DEPTH];
    logic [7:0] rd_q;
    logic [7:0] dbg_q;

    // NOTE: storage arrays carry no reset; clearing them would forbid RAM inference.
    always_ff @(posedge clk) begin
      if (i_we[l]) bank_q[i_addr] <= i_wdata[8*l +: 8];
    end

    always_ff @(posedge clk) begin
      if (i_en) rd_q <= bank_q[i_addr];
    end

    always_ff @(posedge clk) begin
      if (i_rst)     dbg_q <= '0;
      else if (i_en) dbg_q <= bank_q[i_dbg_addr];
    end

    assign o_rdata[8*l +: 8]    = rd_q;
    assign o_dbg_data[8*l +: 8] = dbg_q;
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: alignment check, fixed-latency access FSM with stall,
// byte-lane stores, extended loads and registered MEM/WB outputs.
module mem_stage_lsu
  import mem_lsu_pkg::*;
#(
  parameter  int NB_DATA     = 32,
  parameter  int NB_ADDR     = 10,
  parameter  int NB_REG      = 5,
  parameter  int MEM_LATENCY = 1,
  localparam int LANES       = NB_DATA / 8,
  localparam int LANE_BITS   = $clog2(LANES)
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_halt,
  input  logic [NB_REG-1:0]            i_reg2write,
  input  logic [NB_DATA-1:0]           i_result,
  input  logic [1:0]                   i_width,
  input  logic                         i_sign_flag,
  input  logic                         i_memRead,
  input  logic                         i_memWrite,
  input  logic                         i_mem2reg,
  input  logic                         i_regWrite,
  input  logic [NB_DATA-1:0]           i_data4Mem,
  input  logic [NB_ADDR-LANE_BITS-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]           o_dbg_data,
  output logic                         o_stall,
  output logic                         o_misaligned,
  output logic [NB_DATA-1:0]           o_reg_read,
  output logic [NB_DATA-1:0]           o_ALUresult,
  output logic [NB_REG-1:0]            o_reg2write,
  output logic                         o_mem2reg,
  output logic                         o_regWrite
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef struct packed {
    logic [NB_DATA-1:0] reg_read;
    logic [NB_DATA-1:0] alu;
    logic [NB_REG-1:0]  reg2write;
    logic               mem2reg;
    logic               reg_write;
    logic               misaligned;
  } wb_t;

  logic [NB_ADDR-1:0]           addr;
  logic [NB_ADDR-LANE_BITS-1:0] word_addr;
  logic [2:0]                   lane_off;
  width_e                       width;
  logic                         is_access;
  logic                         legal;
  logic                         finish;
  logic                         pass_thru;
  logic [LANES-1:0]             byte_en;
  logic [LANES-1:0]             ram_we;
  logic [NB_DATA-1:0]           ram_wdata;
  logic [NB_DATA-1:0]           ram_rdata;
  logic [NB_DATA-1:0]           load_data;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  wb_t               wb_q, wb_d;

  assign addr      = i_result[NB_ADDR-1:0];
  assign word_addr = addr[NB_ADDR-1:LANE_BITS];
  assign width     = width_e'(i_width);
  assign is_access = i_memRead | i_memWrite;

  always_comb begin
    lane_off                  = '0;
    lane_off[LANE_BITS-1:0]   = addr[LANE_BITS-1:0];
  end

  assign legal     = is_aligned(width, lane_off, NB_DATA == 64);
  assign byte_en   = LANES'(gen_byte_en(width, lane_off));
  assign ram_wdata = i_data4Mem << {lane_off, 3'b000};
  assign load_data = NB_DATA'(load_extract(64'(ram_rdata), lane_off, width, i_sign_flag));

  // A store caught by reset on its final edge must not reach the RAM.
  assign ram_we = (finish && i_memWrite && !i_halt && !i_rst) ? byte_en : '0;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    o_stall   = 1'b0;
    finish    = 1'b0;
    pass_thru = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_access && legal) begin
          o_stall = !i_halt;
          state_d = S_BUSY;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
        end else begin
          pass_thru = 1'b1;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          o_stall = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_d = wb_q;
    if (pass_thru) begin
      wb_d.reg_read   = '0;
      wb_d.alu        = i_result;
      wb_d.reg2write  = i_reg2write;
      wb_d.mem2reg    = i_mem2reg;
      wb_d.reg_write  = i_regWrite & ~is_access;
      wb_d.misaligned = is_access;
    end else if (finish) begin
      wb_d.reg_read   = load_data;
      wb_d.alu        = i_result;
      wb_d.reg2write  = i_reg2write;
      wb_d.mem2reg    = i_mem2reg;
      wb_d.reg_write  = i_regWrite;
      wb_d.misaligned = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
    end else if (!i_halt) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
    end
  end

  byte_lane_ram #(
    .LANES    (LANES),
    .NB_WADDR (NB_ADDR - LANE_BITS)
  ) u_ram (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_en       (!i_halt),
    .i_addr     (word_addr),
    .i_we       (ram_we),
    .i_wdata    (ram_wdata),
    .o_rdata    (ram_rdata),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  assign o_reg_read   = wb_q.reg_read;
  assign o_ALUresult  = wb_q.alu;
  assign o_reg2write  = wb_q.reg2write;
  assign o_mem2reg    = wb_q.mem2reg;
  assign o_regWrite   = wb_q.reg_write;
  assign o_misaligned = wb_q.misaligned;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: instance 0 runs MEM_LATENCY=1, instance 1 MEM_LATENCY=3.
module tb_mem_stage_lsu;

  localparam int N_DUT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        halt      [N_DUT];
  logic [4:0]  reg2write [N_DUT];
  logic [31:0] result    [N_DUT];
  logic [1:0]  width     [N_DUT];
  logic        sign      [N_DUT];
  logic        mem_read  [N_DUT];
  logic        mem_write [N_DUT];
  logic        mem2reg   [N_DUT];
  logic        reg_write [N_DUT];
  logic [31:0] data4mem  [N_DUT];
  logic [7:0]  dbg_addr  [N_DUT];

  logic [31:0] dbg_data   [N_DUT];
  logic        stall      [N_DUT];
  logic        misaligned [N_DUT];
  logic [31:0] reg_read   [N_DUT];
  logic [31:0] alu_res    [N_DUT];
  logic [4:0]  r2w_o      [N_DUT];
  logic        m2r_o      [N_DUT];
  logic        rw_o       [N_DUT];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    mem_stage_lsu #(
      .NB_DATA     (32),
      .NB_ADDR     (10),
      .NB_REG      (5),
      .MEM_LATENCY ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk          (clk),
      .i_rst        (rst),
      .i_halt       (halt[g]),
      .i_reg2write  (reg2write[g]),
      .i_result     (result[g]),
      .i_width      (width[g]),
      .i_sign_flag  (sign[g]),
      .i_memRead    (mem_read[g]),
      .i_memWrite   (mem_write[g]),
      .i_mem2reg    (mem2reg[g]),
      .i_regWrite   (reg_write[g]),
      .i_data4Mem   (data4mem[g]),
      .i_dbg_addr   (dbg_addr[g]),
      .o_dbg_data   (dbg_data[g]),
      .o_stall      (stall[g]),
      .o_misaligned (misaligned[g]),
      .o_reg_read   (reg_read[g]),
      .o_ALUresult  (alu_res[g]),
      .o_reg2write  (r2w_o[g]),
      .o_mem2reg    (m2r_o[g]),
      .o_regWrite   (rw_o[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle(input int d);
    halt[d]      = 1'b0;
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    mem2reg[d]   = 1'b0;
    reg_write[d] = 1'b0;
    reg2write[d] = '0;
    result[d]    = '0;
    width[d]     = 2'b00;
    sign[d]      = 1'b0;
    data4mem[d]  = '0;
  endtask

  // Starts at a negedge; counts stall cycles, optionally halting for halt_len cycles
  // starting at cycle halt_at; returns at the negedge right after the completing edge.
  task automatic access(input int d, input logic rd, input logic wr, input logic [1:0] w,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input int halt_at, input int halt_len, output int stalls);
    result[d]    = addr;
    mem_read[d]  = rd;
    mem_write[d] = wr;
    width[d]     = w;
    sign[d]      = sgn;
    data4mem[d]  = wdata;
    reg_write[d] = 1'b1;
    mem2reg[d]   = rd;
    reg2write[d] = 5'd3;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      halt[d] = (i >= halt_at) && (i < halt_at + halt_len);
      #1;
      if (!stall[d]) break;
      stalls++;
      @(negedge clk);
    end
    halt[d] = 1'b0;
    @(negedge clk);
    set_idle(d);
  endtask

  task automatic dbg_read(input int d, input logic [7:0] waddr, output logic [31:0] val);
    dbg_addr[d] = waddr;
    @(negedge clk);
    val = dbg_data[d];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          st;
    logic [31:0] v;

    rst = 1'b1;
    for (int d = 0; d < N_DUT; d++) begin
      set_idle(d);
      dbg_addr[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < N_DUT; d++) begin
      #1;
      check($sformatf("rst_reg_read%0d", d), reg_read[d], 0);
      check($sformatf("rst_alu%0d", d), alu_res[d], 0);
      check($sformatf("rst_regwrite%0d", d), rw_o[d], 0);
      check($sformatf("rst_mis%0d", d), misaligned[d], 0);
      check($sformatf("rst_stall%0d", d), stall[d], 0);
      check($sformatf("rst_dbg%0d", d), dbg_data[d], 0);
    end
    @(negedge clk);

    // R-type pass-through
    result[0] = 32'h55; reg2write[0] = 5'd7; reg_write[0] = 1'b1;
    #1 check("rtype_stall", stall[0], 0);
    @(negedge clk);
    check("rtype_alu", alu_res[0], 32'h55);
    check("rtype_r2w", r2w_o[0], 7);
    check("rtype_rw", rw_o[0], 1);
    check("rtype_mis", misaligned[0], 0);
    set_idle(0);

    // Latency 1: byte store into a preloaded word, then loads
    access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h010, 32'h44332211, 0, 0, st);
    check("st_word_stalls", st, 1);
    access(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h013, 32'h000000A5, 0, 0, st);
    check("st_byte_stalls", st, 1);
    access(0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h013, 32'h0, 0, 0, st);
    check("ldb_s_stalls", st, 1);
    check("ldb_s", reg_read[0], 32'hFFFFFFA5);
    check("ldb_s_alu", alu_res[0], 32'h013);
    check("ldb_s_rw", rw_o[0], 1);
    check("ldb_s_r2w", r2w_o[0], 3);
    check("ldb_s_m2r", m2r_o[0], 1);
    access(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h013, 32'h0, 0, 0, st);
    check("ldb_u", reg_read[0], 32'h000000A5);
    access(0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h012, 32'h0, 0, 0, st);
    check("ldh_s", reg_read[0], 32'hFFFFA533);
    access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 0, 0, st);
    check("ldw", reg_read[0], 32'hA5332211);
    dbg_read(0, 8'h04, v);
    check("dbg_w010", v, 32'hA5332211);

    // Read+write together acts as a store and returns the pre-write data
    access(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h010, 32'h0000007F, 0, 0, st);
    check("rw_both_stalls", st, 1);
    check("rw_both_old", reg_read[0], 32'h00000011);
    dbg_read(0, 8'h04, v);
    check("rw_both_dbg", v, 32'hA533227F);

    // Misaligned half store and illegal doubleword
    access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h020, 32'h01020304, 0, 0, st);
    access(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h021, 32'h00001234, 0, 0, st);
    check("mis_h_stalls", st, 0);
    check("mis_h_flag", misaligned[0], 1);
    check("mis_h_rw", rw_o[0], 0);
    dbg_read(0, 8'h08, v);
    check("mis_h_dbg", v, 32'h01020304);
    check("mis_clear", misaligned[0], 0);
    access(0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h000, 32'h0, 0, 0, st);
    check("ill_d_stalls", st, 0);
    check("ill_d_flag", misaligned[0], 1);
    check("ill_d_rw", rw_o[0], 0);

    // Latency 3: word store/load
    access(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h040, 32'hDEADBEEF, 0, 0, st);
    check("l3_st_stalls", st, 3);
    access(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h040, 32'h0, 0, 0, st);
    check("l3_ld_stalls", st, 3);
    check("l3_ld", reg_read[1], 32'hDEADBEEF);

    // Halt for 5 cycles while BUSY with cnt=2
    access(1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h041, 32'h0, 1, 5, st);
    check("halt_stalls", st, 8);
    check("halt_ld", reg_read[1], 32'hFFFFFFBE);

    // Reset on the final edge of a store aborts it
    access(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h080, 32'h11223344, 0, 0, st);
    check("pre_rst_alu", alu_res[1], 32'h080);
    result[1] = 32'h080; mem_write[1] = 1'b1; width[1] = 2'b10;
    data4mem[1] = 32'hCAFEBABE; reg_write[1] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_idle(1);
    #1;
    check("abort_alu", alu_res[1], 0);
    check("abort_rw", rw_o[1], 0);
    check("abort_stall", stall[1], 0);
    check("abort_mis", misaligned[1], 0);
    @(negedge clk);
    access(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h080, 32'h0, 0, 0, st);
    check("abort_idle_stalls", st, 3);
    check("abort_mem", reg_read[1], 32'h11223344);
    dbg_read(1, 8'h20, v);
    check("abort_dbg", v, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
